// File: rtl/alu_op_driver.sv
// alu_op_driver
//   Sequences one two-operand command into a downstream op cell: sends
//   operand A, then operand B, waits a bounded time for the cell's result,
//   and returns it (or a timeout error) upstream.
//
//   Ports
//     i_clk, i_rst                 clock, async active-high reset
//     i_cmd_valid / o_cmd_ready    upstream command handshake
//     i_cmd_a, i_cmd_b             operands, latched on acceptance
//     o_data_valid, o_data         operand beats to the op cell
//     i_result_valid, i_result     op cell result
//     o_result_ready               result taken (cell emptied) this cycle
//     o_rsp_valid / i_rsp_ready    upstream response handshake
//     o_rsp, o_rsp_err             response data, timeout flag
//     o_busy                       state is not IDLE
//
//   state  | meaning
//   IDLE   | ready for a command
//   SEND_A | operand A driven to the cell
//   SEND_B | operand B driven to the cell, wait counter cleared
//   WAIT   | waiting for the cell result, bounded by TIMEOUT cycles
//   RESP   | response held until upstream accepts it

module alu_op_driver #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [WIDTH-1:0] i_cmd_a,
  input  logic [WIDTH-1:0] i_cmd_b,
  output logic             o_data_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_result_valid,
  input  logic [WIDTH-1:0] i_result,
  output logic             o_result_ready,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp,
  output logic             o_rsp_err,
  output logic             o_busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEND_A = 3'd1;
  localparam logic [2:0] S_SEND_B = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  // Last WAIT cycle index; the counter is 8 bits since TIMEOUT tops out at 255.
  localparam logic [7:0] LP_TC = 8'(TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rsp;
  logic             r_rsp_err;
  logic [7:0]       r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_rsp     <= '0;
      r_rsp_err <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_a     <= i_cmd_a;
            r_b     <= i_cmd_b;
            r_state <= S_SEND_A;
          end
        end
        S_SEND_A: r_state <= S_SEND_B;
        S_SEND_B: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving on the last allowed cycle still wins over timeout.
          if (i_result_valid) begin
            r_rsp     <= i_result;
            r_rsp_err <= 1'b0;
            r_state   <= S_RESP;
          end else if (r_cnt == LP_TC) begin
            r_rsp     <= '0;
            r_rsp_err <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // All outputs come from state and registers only, so a reset drives them
  // to their idle values without waiting for a clock edge.
  assign o_cmd_ready    = (r_state == S_IDLE);
  assign o_busy         = (r_state != S_IDLE);
  assign o_data_valid   = (r_state == S_SEND_A) || (r_state == S_SEND_B);
  assign o_data         = (r_state == S_SEND_A) ? r_a :
                          (r_state == S_SEND_B) ? r_b : '0;
  assign o_result_ready = (r_state == S_WAIT);
  assign o_rsp_valid    = (r_state == S_RESP);
  assign o_rsp          = r_rsp;
  assign o_rsp_err      = r_rsp_err;

endmodule

// File: tb/tb_alu_op_driver.sv
module tb_alu_op_driver;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [WIDTH-1:0] i_cmd_a;
  logic [WIDTH-1:0] i_cmd_b;
  logic             o_data_valid;
  logic [WIDTH-1:0] o_data;
  logic             i_result_valid;
  logic [WIDTH-1:0] i_result;
  logic             o_result_ready;
  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic [WIDTH-1:0] o_rsp;
  logic             o_rsp_err;
  logic             o_busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_op_driver #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_cmd_valid    (i_cmd_valid),
    .o_cmd_ready    (o_cmd_ready),
    .i_cmd_a        (i_cmd_a),
    .i_cmd_b        (i_cmd_b),
    .o_data_valid   (o_data_valid),
    .o_data         (o_data),
    .i_result_valid (i_result_valid),
    .i_result       (i_result),
    .o_result_ready (o_result_ready),
    .o_rsp_valid    (o_rsp_valid),
    .i_rsp_ready    (i_rsp_ready),
    .o_rsp          (o_rsp),
    .o_rsp_err      (o_rsp_err),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          delay;     // WAIT cycles before the cell presents its result
    int          stall;     // cycles upstream holds i_rsp_ready low
    logic [31:0] exp_rsp;
    logic        exp_err;
    int          exp_wait;  // WAIT cycles spent before RESP
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: an AND cell that answers after 'delay'
  // WAIT cycles, against a driver that gives up after TIMEOUT WAIT cycles.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input int delay,
                       output logic [31:0] rsp, output logic err, output int waitc);
    if (delay < TIMEOUT) begin
      rsp = a & b; err = 1'b0; waitc = delay + 1;
    end else begin
      rsp = 32'h0; err = 1'b1; waitc = TIMEOUT;
    end
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int delay,
                         input int stall, input logic [31:0] exp_rsp, input logic exp_err,
                         input int exp_wait);
    int w;
    chk("idle_cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("idle_busy", 32'(o_busy), 32'd0);
    i_cmd_valid = 1'b1; i_cmd_a = a; i_cmd_b = b;
    tick();
    i_cmd_valid = 1'b0; i_cmd_a = $urandom; i_cmd_b = $urandom;
    chk("beat_a_valid", 32'(o_data_valid), 32'd1);
    chk("beat_a_data", o_data, a);
    chk("beat_a_cmd_ready", 32'(o_cmd_ready), 32'd0);
    chk("beat_a_busy", 32'(o_busy), 32'd1);
    tick();
    chk("beat_b_valid", 32'(o_data_valid), 32'd1);
    chk("beat_b_data", o_data, b);
    chk("beat_b_result_ready", 32'(o_result_ready), 32'd0);
    tick();
    w = 0;
    while (o_rsp_valid !== 1'b1 && w < TIMEOUT + 4) begin
      chk("wait_result_ready", 32'(o_result_ready), 32'd1);
      chk("wait_no_beat", 32'(o_data_valid), 32'd0);
      chk("wait_data_zero", o_data, 32'h0);
      i_result_valid = (w == delay);
      i_result = (w == delay) ? (a & b) : $urandom;
      tick();
      w++;
    end
    i_result_valid = 1'b0;
    chk("rsp_valid", 32'(o_rsp_valid), 32'd1);
    chk("wait_cycles", 32'(w), 32'(exp_wait));
    chk("rsp_data", o_rsp, exp_rsp);
    chk("rsp_err", 32'(o_rsp_err), 32'(exp_err));
    for (int s = 0; s < stall; s++) begin
      // Stray cell results during RESP must be ignored.
      i_result_valid = 1'b1; i_result = $urandom;
      tick();
      chk("stall_rsp_valid", 32'(o_rsp_valid), 32'd1);
      chk("stall_rsp_data", o_rsp, exp_rsp);
      chk("stall_rsp_err", 32'(o_rsp_err), 32'(exp_err));
      chk("stall_result_ready", 32'(o_result_ready), 32'd0);
      chk("stall_cmd_ready", 32'(o_cmd_ready), 32'd0);
    end
    i_result_valid = 1'b0;
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    chk("done_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("done_cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("done_busy", 32'(o_busy), 32'd0);
    chk("done_rsp_hold", o_rsp, exp_rsp);
  endtask

  initial begin
    logic [31:0] ra, rb, ersp;
    logic        eerr;
    int          rdel, rstall, ewait;

    vecs[0] = '{32'h1B, 32'h0E, 0, 0, 32'h0A, 1'b0, 1};
    vecs[1] = '{32'h3F, 32'h38, 0, 5, 32'h38, 1'b0, 1};
    vecs[2] = '{32'hDEAD_BEEF, 32'hFFFF_0000, 99, 1, 32'h0, 1'b1, 16};
    vecs[3] = '{32'hF0F0_1234, 32'h0FF0_FFFF, 15, 0, 32'h00F0_1234, 1'b0, 16};
    vecs[4] = '{32'hAAAA_5555, 32'h5555_FFFF, 16, 0, 32'h0, 1'b1, 16};
    vecs[5] = '{32'hFFFF_FFFF, 32'h1234_5678, 3, 2, 32'h1234_5678, 1'b0, 4};
    vecs[6] = '{32'h8000_00C3, 32'hC000_0081, 14, 0, 32'h8000_0081, 1'b0, 15};

    rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_a = '0; i_cmd_b = '0;
    i_result_valid = 1'b0; i_result = '0; i_rsp_ready = 1'b0;
    #12;
    chk("reset_cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_data_valid", 32'(o_data_valid), 32'd0);
    chk("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("reset_rsp", o_rsp, 32'h0);
    chk("reset_result_ready", 32'(o_result_ready), 32'd0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_txn(vecs[i].a, vecs[i].b, vecs[i].delay, vecs[i].stall,
              vecs[i].exp_rsp, vecs[i].exp_err, vecs[i].exp_wait);

    // Stray result pulse in IDLE is ignored.
    i_result_valid = 1'b1; i_result = 32'h5A5A_5A5A;
    tick();
    i_result_valid = 1'b0;
    chk("idle_pulse_result_ready", 32'(o_result_ready), 32'd0);
    chk("idle_pulse_busy", 32'(o_busy), 32'd0);
    chk("idle_pulse_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("idle_pulse_rsp", o_rsp, 32'h8000_0081);

    // Reset during SEND_B abandons the transaction asynchronously.
    i_cmd_valid = 1'b1; i_cmd_a = 32'h1111_2222; i_cmd_b = 32'h3333_4444;
    tick();
    i_cmd_valid = 1'b0;
    tick();
    chk("pre_rst_beat_b", o_data, 32'h3333_4444);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("async_rst_data_valid", 32'(o_data_valid), 32'd0);
    chk("async_rst_data", o_data, 32'h0);
    chk("async_rst_result_ready", 32'(o_result_ready), 32'd0);
    chk("async_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("async_rst_rsp", o_rsp, 32'h0);
    chk("async_rst_err", 32'(o_rsp_err), 32'd0);
    chk("async_rst_busy", 32'(o_busy), 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_result_valid = 1'b1; i_result = $urandom;
      tick();
      chk("post_rst_no_beat", 32'(o_data_valid), 32'd0);
      chk("post_rst_no_rsp", 32'(o_rsp_valid), 32'd0);
    end
    i_result_valid = 1'b0;
    run_txn(32'h0000_00FF, 32'h0000_0F0F, 2, 1, 32'h0000_000F, 1'b0, 3);

    // Randomized transactions against the reference model.
    for (int r = 0; r < 30; r++) begin
      ra = $urandom; rb = $urandom;
      rdel = $urandom_range(0, TIMEOUT + 4);
      rstall = $urandom_range(0, 3);
      model(ra, rb, rdel, ersp, eerr, ewait);
      run_txn(ra, rb, rdel, rstall, ersp, eerr, ewait);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
